// File: rtl/sprite_bounce_engine.sv
// Bouncing-sprite renderer: moves a box once per frame inside the drawable area,
// reflects it off the edges and produces registered RGB with a fixed 3-cycle latency.
module sprite_bounce_engine #(
   parameter int          CW           = 16,
   parameter int          AREA_W       = 640,
   parameter int          AREA_H       = 480,
   parameter int          BOX_W        = 50,
   parameter int          BOX_H        = 50,
   parameter int          SPEED_X      = 1,
   parameter int          SPEED_Y      = 1,
   parameter int          INIT_X       = 0,
   parameter int          INIT_Y       = 0,
   parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
   parameter logic [23:0] SPR_BG_COLOR = 24'h000000,
   parameter logic [23:0] BG_COLOR     = 24'h000000,
   parameter int          TRANSPARENT  = 0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_frame_tick,
   input  logic          i_enable,
   input  logic [CW-1:0] i_x,
   input  logic [CW-1:0] i_y,
   input  logic          i_pix_valid,
   output logic [CW-1:0] o_px,
   output logic [CW-1:0] o_py,
   input  logic          i_data,
   output logic [7:0]    o_r,
   output logic [7:0]    o_g,
   output logic [7:0]    o_b,
   output logic          o_rgb_valid,
   output logic [CW-1:0] o_box_x,
   output logic [CW-1:0] o_box_y,
   output logic          o_hit_x,
   output logic          o_hit_y,
   output logic [15:0]   o_bounce_cnt
);

   localparam logic [0:0]    DIR_POS = 1'b0;
   localparam logic [0:0]    DIR_NEG = 1'b1;
   localparam logic [CW-1:0] MAX_X   = CW'(AREA_W - BOX_W);
   localparam logic [CW-1:0] MAX_Y   = CW'(AREA_H - BOX_H);
   localparam logic [CW-1:0] STEP_X  = CW'(SPEED_X);
   localparam logic [CW-1:0] STEP_Y  = CW'(SPEED_Y);
   localparam logic [CW-1:0] BOX_WC  = CW'(BOX_W);
   localparam logic [CW-1:0] BOX_HC  = CW'(BOX_H);
   localparam logic [CW-1:0] INIT_XC = CW'(INIT_X);
   localparam logic [CW-1:0] INIT_YC = CW'(INIT_Y);

   logic [CW-1:0] r_boxX, r_boxY;
   logic [0:0]    r_dirX, r_dirY;
   logic          r_hitX, r_hitY;
   logic [15:0]   r_bounceCnt;

   logic [CW-1:0] w_nextX, w_nextY;
   logic [0:0]    w_nextDirX, w_nextDirY;
   logic          w_hitX, w_hitY;
   logic [15:0]   w_hitSum;
   logic [15:0]   w_nextCnt;

   // Landing on or past an edge clamps to it and counts as a reflection.
   always_comb begin
      w_nextX    = r_boxX;
      w_nextDirX = r_dirX;
      w_hitX     = 1'b0;
      if (r_dirX == DIR_POS) begin
         if (r_boxX + STEP_X >= MAX_X) begin
            w_nextX    = MAX_X;
            w_nextDirX = DIR_NEG;
            w_hitX     = 1'b1;
         end else begin
            w_nextX = r_boxX + STEP_X;
         end
      end else begin
         if (r_boxX <= STEP_X) begin
            w_nextX    = '0;
            w_nextDirX = DIR_POS;
            w_hitX     = 1'b1;
         end else begin
            w_nextX = r_boxX - STEP_X;
         end
      end

      w_nextY    = r_boxY;
      w_nextDirY = r_dirY;
      w_hitY     = 1'b0;
      if (r_dirY == DIR_POS) begin
         if (r_boxY + STEP_Y >= MAX_Y) begin
            w_nextY    = MAX_Y;
            w_nextDirY = DIR_NEG;
            w_hitY     = 1'b1;
         end else begin
            w_nextY = r_boxY + STEP_Y;
         end
      end else begin
         if (r_boxY <= STEP_Y) begin
            w_nextY    = '0;
            w_nextDirY = DIR_POS;
            w_hitY     = 1'b1;
         end else begin
            w_nextY = r_boxY - STEP_Y;
         end
      end
   end

   // A corner hit adds two; the counter sticks at all-ones.
   always_comb begin
      w_hitSum  = {15'd0, w_hitX} + {15'd0, w_hitY};
      w_nextCnt = r_bounceCnt + w_hitSum;
      if (r_bounceCnt > (16'hFFFF - w_hitSum)) begin
         w_nextCnt = 16'hFFFF;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_boxX      <= INIT_XC;
         r_boxY      <= INIT_YC;
         r_dirX      <= DIR_POS;
         r_dirY      <= DIR_POS;
         r_hitX      <= 1'b0;
         r_hitY      <= 1'b0;
         r_bounceCnt <= '0;
      end else begin
         r_hitX <= 1'b0;
         r_hitY <= 1'b0;
         if (i_frame_tick && i_enable) begin
            r_boxX      <= w_nextX;
            r_boxY      <= w_nextY;
            r_dirX      <= w_nextDirX;
            r_dirY      <= w_nextDirY;
            r_hitX      <= w_hitX;
            r_hitY      <= w_hitY;
            r_bounceCnt <= w_nextCnt;
         end
      end
   end

   logic          w_in;
   logic [CW-1:0] r_px, r_py;
   logic          r_in1, r_in2, r_valid1, r_valid2;
   logic [23:0]   w_color;
   logic [23:0]   r_rgb;
   logic          r_rgbValid;

   assign w_in = i_pix_valid
              && (i_x >= r_boxX) && (i_x < r_boxX + BOX_WC)
              && (i_y >= r_boxY) && (i_y < r_boxY + BOX_HC);

   // The ROM bit arrives alongside r_in2, so the colour decision uses both.
   always_comb begin
      w_color = BG_COLOR;
      if (r_in2 && i_data) begin
         w_color = FG_COLOR;
      end else if (r_in2 && (TRANSPARENT == 0)) begin
         w_color = SPR_BG_COLOR;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_px       <= '0;
         r_py       <= '0;
         r_in1      <= 1'b0;
         r_valid1   <= 1'b0;
         r_in2      <= 1'b0;
         r_valid2   <= 1'b0;
         r_rgb      <= '0;
         r_rgbValid <= 1'b0;
      end else begin
         r_px       <= w_in ? (i_x - r_boxX) : '0;
         r_py       <= w_in ? (i_y - r_boxY) : '0;
         r_in1      <= w_in;
         r_valid1   <= i_pix_valid;
         r_in2      <= r_in1;
         r_valid2   <= r_valid1;
         r_rgb      <= w_color;
         r_rgbValid <= r_valid2;
      end
   end

   assign o_px         = r_px;
   assign o_py         = r_py;
   assign o_r          = r_rgb[23:16];
   assign o_g          = r_rgb[15:8];
   assign o_b          = r_rgb[7:0];
   assign o_rgb_valid  = r_rgbValid;
   assign o_box_x      = r_boxX;
   assign o_box_y      = r_boxY;
   assign o_hit_x      = r_hitX;
   assign o_hit_y      = r_hitY;
   assign o_bounce_cnt = r_bounceCnt;

endmodule
